// File: rtl/mem_io_responder_pkg.sv
// Shared constants, address-region type and decode helper for the CPU byte-bus responder.
package mem_io_responder_pkg;

   localparam logic [1:0]  IO_BASE_HI   = 2'b11;
   localparam logic [17:0] IO_UART_ADDR = 18'h30000;
   localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;
   localparam int unsigned RAM_SIZE     = 1 << 17;

   typedef enum logic [1:0] {
      REGION_RAM,
      REGION_HOLE,
      REGION_IO
   } addr_region_t;

   function automatic addr_region_t addr_region(input logic [17:0] a);
      if (a[17:16] == IO_BASE_HI) begin
         return REGION_IO;
      end else if (!a[17]) begin
         return REGION_RAM;
      end else begin
         return REGION_HOLE;
      end
   endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// CPU byte memory bus: address, write strobe, data in both directions and back-pressure flag.
interface mem_io_responder_if;

   logic [31:0] cpu_a;
   logic        cpu_wr;
   logic [7:0]  cpu_dout;
   logic [7:0]  cpu_din;
   logic        io_buffer_full;

   modport master (
      output cpu_a,
      output cpu_wr,
      output cpu_dout,
      input  cpu_din,
      input  io_buffer_full
   );

   modport slave (
      input  cpu_a,
      input  cpu_wr,
      input  cpu_dout,
      output cpu_din,
      output io_buffer_full
   );

endinterface

// File: rtl/mem_io_responder_sync_byte_fifo.sv
// Power-of-two circular byte FIFO with occupancy count; push while full is dropped unless popping.
module sync_byte_fifo #(
   parameter int unsigned DEPTH_LOG2 = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [7:0]            push_data,
   input  logic                  pop,
   output logic [7:0]            head,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned PW    = DEPTH_LOG2;
   localparam int unsigned CW    = DEPTH_LOG2 + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   assign full    = (count_q == DEPTH_C);
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];
   assign do_pop  = pop && !empty;
   // At full, a concurrent pop frees the slot the push lands in.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/mem_io_responder.sv
// CPU bus slave: byte RAM, UART RX/TX and cycle-counter I/O at 0x30000/0x30004.
module mem_io_responder
   import mem_io_responder_pkg::*;
#(
   parameter int unsigned RAM_ADDR_W    = $clog2(RAM_SIZE),
   parameter int unsigned TX_DEPTH_LOG2 = 3,
   parameter int unsigned FULL_MARGIN   = 2
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               rdy_in,
   mem_io_responder_if.slave  cpu,
   input  logic               uart_rx_valid,
   input  logic [7:0]         uart_rx_data,
   output logic               uart_rx_pop,
   output logic               uart_tx_valid,
   output logic [7:0]         uart_tx_data,
   input  logic               uart_tx_ready,
   output logic               program_done
);

   localparam int unsigned CW = TX_DEPTH_LOG2 + 1;
   localparam logic [CW-1:0] TX_DEPTH = CW'(1 << TX_DEPTH_LOG2);
   localparam logic [CW-1:0] MARGIN   = CW'(FULL_MARGIN);

   logic [7:0]            ram [2**RAM_ADDR_W];
   logic [17:0]           a;
   logic [RAM_ADDR_W-1:0] ram_idx;
   addr_region_t          region;
   logic                  is_uart;
   logic                  is_clk;
   logic                  is_clk_grp;
   logic [7:0]            rd_data;
   logic [7:0]            din_q;
   logic [31:0]           counter_q;
   logic [31:8]           snap_q;
   logic                  done_q;
   logic                  tx_push;
   logic [7:0]            tx_push_data;
   logic                  tx_pop;
   logic                  tx_full;
   logic                  tx_empty;
   logic [CW-1:0]         tx_count;

   assign a          = cpu.cpu_a[17:0];
   assign ram_idx    = cpu.cpu_a[RAM_ADDR_W-1:0];
   assign region     = addr_region(a);
   assign is_uart    = (region == REGION_IO) && (a == IO_UART_ADDR);
   assign is_clk     = (region == REGION_IO) && (a == IO_CLK_ADDR);
   assign is_clk_grp = (region == REGION_IO) && (a[17:2] == IO_CLK_ADDR[17:2]);

   // Byte 0 comes from the live counter; that same read latches the upper bytes.
   always_comb begin
      rd_data = 8'h00;
      if (region == REGION_RAM) begin
         rd_data = ram[ram_idx];
      end else if (is_uart) begin
         rd_data = uart_rx_valid ? uart_rx_data : 8'h00;
      end else if (is_clk_grp) begin
         case (a[1:0])
            2'd0:    rd_data = counter_q[7:0];
            2'd1:    rd_data = snap_q[15:8];
            2'd2:    rd_data = snap_q[23:16];
            default: rd_data = snap_q[31:24];
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (cpu.cpu_wr && region == REGION_RAM) begin
         ram[ram_idx] <= cpu.cpu_dout;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         din_q     <= 8'h00;
         counter_q <= '0;
         snap_q    <= '0;
         done_q    <= 1'b0;
      end else begin
         if (rdy_in) begin
            counter_q <= counter_q + 32'd1;
         end
         if (!cpu.cpu_wr) begin
            din_q <= rd_data;
            if (is_clk) begin
               snap_q <= counter_q[31:8];
            end
         end else if (is_clk) begin
            done_q <= 1'b1;
         end
      end
   end

   assign tx_push      = cpu.cpu_wr && ((is_uart && cpu.cpu_dout != 8'h00) || is_clk);
   assign tx_push_data = is_clk ? 8'h00 : cpu.cpu_dout;
   assign tx_pop       = uart_tx_valid && uart_tx_ready;

   sync_byte_fifo #(
      .DEPTH_LOG2 (TX_DEPTH_LOG2)
   ) u_tx_fifo (
      .clk       (clk_in),
      .rst       (rst_in),
      .push      (tx_push),
      .push_data (tx_push_data),
      .pop       (tx_pop),
      .head      (uart_tx_data),
      .full      (tx_full),
      .empty     (tx_empty),
      .count     (tx_count)
   );

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         assert (!(tx_push && tx_full && !tx_pop))
            else $error("mem_io_responder: TX FIFO overflow, byte dropped");
      end
   end

   assign uart_tx_valid      = !tx_empty;
   assign uart_rx_pop        = !rst_in && !cpu.cpu_wr && is_uart && uart_rx_valid;
   assign program_done       = done_q;
   assign cpu.cpu_din        = din_q;
   // Count is already the post-update registered value, so this flag is effectively registered.
   assign cpu.io_buffer_full = (TX_DEPTH - tx_count) <= MARGIN;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder: RAM, hole, UART RX/TX, counter snapshot, reset.
module tb_mem_io_responder;

   logic       clk_in = 1'b0;
   logic       rst_in;
   logic       rdy_in;
   logic       uart_rx_valid;
   logic [7:0] uart_rx_data;
   logic       uart_rx_pop;
   logic       uart_tx_valid;
   logic [7:0] uart_tx_data;
   logic       uart_tx_ready;
   logic       program_done;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [31:0] IDLE_A = 32'h0002_0000;
   localparam logic [31:0] UART_A = 32'h0003_0000;
   localparam logic [31:0] CLK_A  = 32'h0003_0004;

   mem_io_responder_if bus ();

   mem_io_responder dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .rdy_in        (rdy_in),
      .cpu           (bus),
      .uart_rx_valid (uart_rx_valid),
      .uart_rx_data  (uart_rx_data),
      .uart_rx_pop   (uart_rx_pop),
      .uart_tx_valid (uart_tx_valid),
      .uart_tx_data  (uart_tx_data),
      .uart_tx_ready (uart_tx_ready),
      .program_done  (program_done)
   );

   always #5 clk_in = ~clk_in;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic drive(input logic wr, input logic [31:0] addr, input logic [7:0] data);
      bus.cpu_wr   = wr;
      bus.cpu_a    = addr;
      bus.cpu_dout = data;
   endtask

   initial begin
      rst_in        = 1'b1;
      rdy_in        = 1'b0;
      uart_rx_valid = 1'b0;
      uart_rx_data  = 8'h00;
      uart_tx_ready = 1'b0;
      drive(1'b0, IDLE_A, 8'h00);
      step();
      step();
      check_eq("rst_din", {24'h0, bus.cpu_din}, 32'h0);
      check_eq("rst_full", {31'h0, bus.io_buffer_full}, 32'h0);
      check_eq("rst_rx_pop", {31'h0, uart_rx_pop}, 32'h0);
      check_eq("rst_tx_valid", {31'h0, uart_tx_valid}, 32'h0);
      check_eq("rst_done", {31'h0, program_done}, 32'h0);

      // Cycle counter: 100 counted cycles, then snapshot reads.
      rst_in = 1'b0;
      rdy_in = 1'b1;
      repeat (100) step();
      drive(1'b0, CLK_A, 8'h00);
      step();
      check_eq("clk100_b0", {24'h0, bus.cpu_din}, 32'h64);
      for (int i = 1; i < 4; i++) begin
         drive(1'b0, CLK_A + 32'(i), 8'h00);
         step();
         check_eq("clk100_bn", {24'h0, bus.cpu_din}, 32'h0);
      end
      rdy_in = 1'b0;
      drive(1'b0, IDLE_A, 8'h00);
      repeat (5) step();
      drive(1'b0, CLK_A, 8'h00);
      step();
      check_eq("clk_frozen", {24'h0, bus.cpu_din}, 32'h68);

      // Reach 0x1FF so byte 1 of the live counter moves on right after the snapshot.
      rdy_in = 1'b1;
      drive(1'b0, IDLE_A, 8'h00);
      repeat (407) step();
      drive(1'b0, CLK_A, 8'h00);
      step();
      check_eq("snap_b0", {24'h0, bus.cpu_din}, 32'hFF);
      drive(1'b0, CLK_A + 32'd2, 8'h00);
      step();
      check_eq("snap_b2", {24'h0, bus.cpu_din}, 32'h00);
      drive(1'b0, CLK_A + 32'd3, 8'h00);
      step();
      check_eq("snap_b3", {24'h0, bus.cpu_din}, 32'h00);
      drive(1'b0, CLK_A + 32'd1, 8'h00);
      step();
      check_eq("snap_b1", {24'h0, bus.cpu_din}, 32'h01);
      rdy_in = 1'b0;

      // RAM, hole and address aliasing.
      drive(1'b1, 32'h0000_0123, 8'hA5);
      step();
      check_eq("din_hold_on_wr", {24'h0, bus.cpu_din}, 32'h01);
      drive(1'b0, 32'h0000_0123, 8'h00);
      step();
      check_eq("ram_rd", {24'h0, bus.cpu_din}, 32'hA5);
      drive(1'b1, 32'h0002_0123, 8'h55);
      step();
      drive(1'b0, 32'h0002_0123, 8'h00);
      step();
      check_eq("hole_rd", {24'h0, bus.cpu_din}, 32'h00);
      drive(1'b0, 32'h0000_0123, 8'h00);
      step();
      check_eq("hole_no_alias", {24'h0, bus.cpu_din}, 32'hA5);
      drive(1'b1, 32'h0001_FFFF, 8'h5A);
      step();
      drive(1'b0, 32'h0001_FFFF, 8'h00);
      step();
      check_eq("ram_top", {24'h0, bus.cpu_din}, 32'h5A);
      drive(1'b0, 32'hFFFC_0123, 8'h00);
      step();
      check_eq("ram_hi_bits", {24'h0, bus.cpu_din}, 32'hA5);

      // UART RX.
      uart_rx_valid = 1'b1;
      uart_rx_data  = 8'h37;
      drive(1'b0, UART_A, 8'h00);
      #1;
      check_eq("rx_pop", {31'h0, uart_rx_pop}, 32'h1);
      step();
      check_eq("rx_data", {24'h0, bus.cpu_din}, 32'h37);
      uart_rx_valid = 1'b0;
      #1;
      check_eq("rx_nopop", {31'h0, uart_rx_pop}, 32'h0);
      step();
      check_eq("rx_empty", {24'h0, bus.cpu_din}, 32'h00);
      uart_rx_valid = 1'b1;
      drive(1'b1, UART_A, 8'h00);
      #1;
      check_eq("rx_pop_on_wr", {31'h0, uart_rx_pop}, 32'h0);
      drive(1'b0, CLK_A + 32'd1, 8'h00);
      #1;
      check_eq("rx_pop_other", {31'h0, uart_rx_pop}, 32'h0);
      uart_rx_valid = 1'b0;
      drive(1'b0, IDLE_A, 8'h00);
      step();

      // UART TX with zero filtering.
      uart_tx_ready = 1'b1;
      drive(1'b1, UART_A, 8'h41);
      step();
      check_eq("tx_valid_41", {31'h0, uart_tx_valid}, 32'h1);
      check_eq("tx_data_41", {24'h0, uart_tx_data}, 32'h41);
      drive(1'b1, UART_A, 8'h00);
      step();
      check_eq("tx_zero_dropped", {31'h0, uart_tx_valid}, 32'h0);
      drive(1'b1, UART_A, 8'h42);
      step();
      check_eq("tx_valid_42", {31'h0, uart_tx_valid}, 32'h1);
      check_eq("tx_data_42", {24'h0, uart_tx_data}, 32'h42);
      drive(1'b0, IDLE_A, 8'h00);
      step();
      check_eq("tx_drained", {31'h0, uart_tx_valid}, 32'h0);

      // Fill to the margin, pop one, then run full with push+pop and drain.
      uart_tx_ready = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         drive(1'b1, UART_A, 8'(i));
         step();
         if (i == 5) check_eq("full_at5", {31'h0, bus.io_buffer_full}, 32'h0);
         if (i == 6) check_eq("full_at6", {31'h0, bus.io_buffer_full}, 32'h1);
      end
      drive(1'b0, IDLE_A, 8'h00);
      uart_tx_ready = 1'b1;
      step();
      check_eq("full_clear", {31'h0, bus.io_buffer_full}, 32'h0);
      check_eq("head_after_pop", {24'h0, uart_tx_data}, 32'h02);
      uart_tx_ready = 1'b0;
      for (int i = 7; i <= 9; i++) begin
         drive(1'b1, UART_A, 8'(i));
         step();
      end
      check_eq("full_at8", {31'h0, bus.io_buffer_full}, 32'h1);
      uart_tx_ready = 1'b1;
      drive(1'b1, UART_A, 8'h0A);
      step();
      check_eq("full_pushpop_head", {24'h0, uart_tx_data}, 32'h03);
      check_eq("full_pushpop_flag", {31'h0, bus.io_buffer_full}, 32'h1);
      drive(1'b0, IDLE_A, 8'h00);
      for (int i = 0; i < 7; i++) begin
         step();
         check_eq("drain_head", {24'h0, uart_tx_data}, 32'(4 + i));
      end
      step();
      check_eq("drain_empty", {31'h0, uart_tx_valid}, 32'h0);

      // program_done, terminator byte and reset mid-operation.
      uart_tx_ready = 1'b0;
      drive(1'b0, 32'h0000_0123, 8'h00);
      step();
      drive(1'b1, CLK_A, 8'h77);
      step();
      check_eq("done_set", {31'h0, program_done}, 32'h1);
      check_eq("done_tx_valid", {31'h0, uart_tx_valid}, 32'h1);
      check_eq("done_tx_nul", {24'h0, uart_tx_data}, 32'h00);
      check_eq("done_din_hold", {24'h0, bus.cpu_din}, 32'hA5);
      drive(1'b0, IDLE_A, 8'h00);
      step();
      check_eq("done_sticky", {31'h0, program_done}, 32'h1);
      drive(1'b0, 32'h0000_0123, 8'h00);
      rst_in = 1'b1;
      step();
      check_eq("rst_mid_din", {24'h0, bus.cpu_din}, 32'h00);
      check_eq("rst_mid_done", {31'h0, program_done}, 32'h0);
      check_eq("rst_mid_tx", {31'h0, uart_tx_valid}, 32'h0);
      rst_in = 1'b0;
      drive(1'b0, CLK_A, 8'h00);
      step();
      check_eq("rst_counter", {24'h0, bus.cpu_din}, 32'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Slave-side endpoint of the CPU byte memory bus (data in/out, address, write strobe, io_buffer_full).
- Contains a single-port byte RAM and the memory-mapped I/O decode at 0x30000 (UART byte / stop) and 0x30004 (cycle counter).
- Contains a UART TX FIFO that drives io_buffer_full back to the CPU.
- Sits between the CPU top and the board UART/HCI, and replaces the stand-alone RAM and IO glue.

Parameters:
- RAM_ADDR_W, 17, RAM byte address width; 2^17 = 128 KiB.
- TX_DEPTH_LOG2, 3, log2 of TX FIFO depth; 8 entries.
- FULL_MARGIN, 2, free-slot threshold at or below which io_buffer_full asserts.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  CPU-active flag; gates the cycle counter only
- cpu_a  in  32  byte address; only bits 17:0 are decoded
- cpu_wr  in  1  1 = write, 0 = read
- cpu_dout  in  8  write data from the CPU
- cpu_din  out  8  read data to the CPU, valid one cycle after the address
- io_buffer_full  out  1  TX FIFO nearly full
- uart_rx_valid  in  1  RX byte available
- uart_rx_data  in  8  RX byte
- uart_rx_pop  out  1  one-cycle pulse; consumes the current RX byte
- uart_tx_valid  out  1  TX FIFO non-empty
- uart_tx_data  out  8  TX FIFO head byte
- uart_tx_ready  in  1  UART accepts the head byte this cycle
- program_done  out  1  sticky; set by a write to 0x30004

Behaviour:
- Reset values: cpu_din = 0, io_buffer_full = 0, uart_rx_pop = 0, uart_tx_valid = 0, program_done = 0. TX FIFO is empty and the cycle counter is 0. RAM contents are not reset.
- Decode: IO when a[17:16] == 2'b11. RAM when a[17] == 0. The hole 0x20000-0x2FFFF reads 0 and ignores writes.
- Every cycle is a bus cycle; there is no request/valid signal. A read registers its result into cpu_din at the next posedge, giving 1-cycle latency. cpu_din holds its value until the next read.
- A write commits at the posedge and takes 1 cycle. On a write cycle cpu_din keeps its previous value.
- RAM read is synchronous read-before-write. A read following a write to the same address in the next cycle returns the new data.
- IO read at 0x30000: returns uart_rx_data if uart_rx_valid, else 0x00. Pulses uart_rx_pop in the same cycle the address is presented, only when valid.
- IO read at 0x30004-0x30007: returns byte a[1:0] of a 32-bit snapshot. The snapshot is latched from the live counter when 0x30004 is read, so a 4-byte read sequence is coherent. Addresses 0x30005-0x30007 read from the snapshot.
- Other IO reads return 0.
- IO write at 0x30000: pushes cpu_dout into the TX FIFO. Value 0x00 is ignored. A push when the FIFO is completely full is dropped; it is a CPU protocol violation, and simulation flags it with an assertion.
- IO write at 0x30004: sets program_done and pushes 0x00 into the TX FIFO (the '\0' terminator). Subsequent writes are still accepted.
- Other IO writes are ignored.
- Cycle counter: 32-bit, +1 every cycle with rdy_in == 1, wraps 0xFFFFFFFF -> 0.
- TX FIFO: circular buffer with count register. A pop happens when uart_tx_valid && uart_tx_ready. Simultaneous push and pop leaves count unchanged and works at both full and empty. Pointers wrap modulo depth. On an empty FIFO, a push becomes visible on uart_tx_valid the following cycle.
- io_buffer_full is registered: 1 when free slots after this cycle's update are <= FULL_MARGIN. The margin covers the CPU seeing the flag one cycle late.
- Reset mid-operation: FIFO contents are discarded, program_done clears, and a pending read result is lost (cpu_din = 0 next cycle).

Decomposition:
- Shared package holds constants IO_BASE_HI = 2'b11, IO_UART_ADDR = 18'h30000, IO_CLK_ADDR = 18'h30004, RAM_SIZE, and the enum addr_region_t {REGION_RAM, REGION_HOLE, REGION_IO}.
- One sub-module is natural: sync_byte_fifo, parameterised by depth, with push/pop/full/empty/count.
- The RAM is an inferred array inside the top; no separate module.

Test Plan:
- Write 0xA5 at 0x00123; read 0x00123 the next cycle -> cpu_din = 0xA5 exactly one cycle after the read address.
- Write 0x41 then 0x00 then 0x42 to 0x30000 with uart_tx_ready = 1 -> uart_tx_data sequence 0x41, 0x42; no 0x00 emitted.
- Hold uart_tx_ready = 0 and write 6 bytes (depth 8, margin 2) -> io_buffer_full = 1 on the cycle after the 6th push; one pop -> flag clears the following cycle.
- Run 100 cycles with rdy_in = 1, then read 0x30004..0x30007 -> bytes form 100 + offset consistently from the snapshot; rdy_in = 0 freezes the count.
- Write 0x30004 -> program_done = 1 and 0x00 appears on uart_tx_data; apply rst_in -> program_done = 0 and uart_tx_valid = 0.
- Read 0x30000 with uart_rx_valid = 1, data 0x37 -> uart_rx_pop pulse and cpu_din = 0x37 next cycle; with rx empty -> cpu_din = 0x00 and no pop.
